// File: rtl/running_light_pkg.sv
// Shared encodings for the running-light sequencer: display modes, scan
// direction, speed-level sizing and per-mode seed patterns.
package running_light_pkg;

    typedef enum logic [1:0] {
        MODE_L2R    = 2'd0,
        MODE_R2L    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int SPEED_LEVELS = 4;
    localparam int SPEED_W      = $clog2(SPEED_LEVELS);

    localparam logic [3:0] SEED_L2R    = 4'b0001;
    localparam logic [3:0] SEED_R2L    = 4'b1000;
    localparam logic [3:0] SEED_BOUNCE = 4'b0001;
    localparam logic [3:0] SEED_BLINK  = 4'b1111;

    function automatic logic [3:0] seed_pattern(input mode_e m);
        case (m)
            MODE_L2R:    seed_pattern = SEED_L2R;
            MODE_R2L:    seed_pattern = SEED_R2L;
            MODE_BOUNCE: seed_pattern = SEED_BOUNCE;
            default:     seed_pattern = SEED_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/running_light_ctrl_step_timer.sv
// Step-rate counter: divides the system clock by (STEP_CNT_MAX+1)>>speed and
// emits a one-cycle step strobe when the count reaches its limit.
module step_timer
    import running_light_pkg::*;
#(
    parameter int STEP_CNT_MAX = 24_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               clr,
    input  logic               hold,
    input  logic [SPEED_W-1:0] speed,
    output logic               step
);

    localparam int             CW     = $clog2(STEP_CNT_MAX + 1);
    // One extra bit so a power-of-two period still fits before the -1.
    localparam logic [CW:0]    PERIOD = (CW+1)'(STEP_CNT_MAX + 1);

    logic [CW-1:0] cnt;
    logic [CW:0]   limit;
    logic          at_limit;

    assign limit    = (PERIOD >> speed) - (CW+1)'(1);
    assign at_limit = ({1'b0, cnt} == limit);
    // A request clear in the same cycle suppresses the step.
    assign step     = at_limit && !hold && !clr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            if (at_limit) cnt <= '0;
            else          cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/running_light_ctrl.sv
// Running-light sequencer: mode/speed registers, the pattern-step FSM
// (pattern plus bounce direction) and the registered step_tick pulse.
module running_light_ctrl
    import running_light_pkg::*;
#(
    parameter int STEP_CNT_MAX = 24_999_999
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               mode_req,
    input  logic               speed_req,
    input  logic               pause,
    output logic [3:0]         led,
    output logic               step_tick,
    output logic [1:0]         mode,
    output logic [SPEED_W-1:0] speed
);

    mode_e              mode_q, mode_d;
    dir_e               dir_q, dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [3:0]         led_q, led_d, led_step;
    logic               tick_q, tick_d;
    logic               step;

    step_timer #(.STEP_CNT_MAX(STEP_CNT_MAX)) u_step_timer (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (mode_req | speed_req),
        .hold    (pause),
        .speed   (speed_q),
        .step    (step)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q  <= MODE_L2R;
            speed_q <= '0;
            led_q   <= SEED_L2R;
            dir_q   <= DIR_UP;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        mode_d   = mode_q;
        speed_d  = speed_q;
        led_d    = led_q;
        dir_d    = dir_q;
        tick_d   = 1'b0;
        led_step = led_q;

        case (mode_q)
            MODE_L2R:    led_step = {led_q[2:0], led_q[3]};
            MODE_R2L:    led_step = {led_q[0], led_q[3:1]};
            MODE_BOUNCE: led_step = (dir_q == DIR_UP) ? (led_q << 1) : (led_q >> 1);
            default:     led_step = ~led_q;
        endcase

        if (mode_req) begin
            mode_d = mode_e'(mode_q + 2'd1);
            led_d  = seed_pattern(mode_d);
            dir_d  = DIR_UP;
        end else if (step) begin
            led_d  = led_step;
            tick_d = 1'b1;
            // Direction turns on arrival at either end of the bar.
            if (mode_q == MODE_BOUNCE) begin
                if (led_step == 4'b1000)      dir_d = DIR_DOWN;
                else if (led_step == 4'b0001) dir_d = DIR_UP;
            end
        end

        if (speed_req) speed_d = speed_q + SPEED_W'(1);
    end

    assign led       = led_q;
    assign mode      = mode_q;
    assign speed     = speed_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_running_light_ctrl.sv
// Scoreboard bench for running_light_ctrl with STEP_CNT_MAX=9: expected step
// ticks (cycle, pattern, mode, speed) are queued by stimulus, popped by a monitor.
module tb_running_light_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       mode_req = 1'b0;
    logic       speed_req = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] led;
    logic       step_tick;
    logic [1:0] mode;
    logic [1:0] speed;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] led;
        logic [1:0] mode;
        logic [1:0] speed;
        int         t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    running_light_ctrl #(.STEP_CNT_MAX(9)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .mode_req  (mode_req),
        .speed_req (speed_req),
        .pause     (pause),
        .led       (led),
        .step_tick (step_tick),
        .mode      (mode),
        .speed     (speed)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic state_chk(input string tag, input logic [3:0] l, input logic [1:0] m,
                             input logic [1:0] s);
        chk({tag, "_led"}, 32'(led), 32'(l));
        chk({tag, "_mode"}, 32'(mode), 32'(m));
        chk({tag, "_speed"}, 32'(speed), 32'(s));
    endtask

    task automatic push(input logic [3:0] l, input logic [1:0] m, input logic [1:0] s,
                        input int t);
        exp_t e;
        e.led = l; e.mode = m; e.speed = s; e.t = t;
        sb.push_back(e);
    endtask

    // Each call lands just after a falling edge, once the monitor has run.
    task automatic step_cyc(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step_cyc(1);
    endtask

    always @(negedge sys_clk) begin
        if (step_tick) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick: got tick at cycle %0d led=%b, expected none", cyc, led);
            end else begin
                mon_e = sb.pop_front();
                chk("tick_cycle", 32'(cyc), 32'(mon_e.t));
                chk("tick_led", 32'(led), 32'(mon_e.led));
                chk("tick_mode", 32'(mode), 32'(mon_e.mode));
                chk("tick_speed", 32'(speed), 32'(mon_e.speed));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        int k;
        int per[4];
        int ns[4];
        logic [3:0] sl[11];
        logic [3:0] bl[8];

        per = '{5, 2, 1, 10};
        ns  = '{3, 3, 3, 2};
        sl  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100,
                4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bl  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};

        // Reset values, then free-run at speed 0
        step_cyc(3);
        state_chk("rst", 4'b0001, 2'd0, 2'd0);
        chk("rst_tick", 32'(step_tick), 32'd0);
        sys_rst = 1'b0;
        t = cyc;
        push(4'b0010, 2'd0, 2'd0, t + 10);
        push(4'b0100, 2'd0, 2'd0, t + 20);
        push(4'b1000, 2'd0, 2'd0, t + 30);
        push(4'b0001, 2'd0, 2'd0, t + 40);
        run_to(t + 40);
        chk("s1_drain", 32'(sb.size()), 32'd0);

        // Speed sweep 1,2,3 then back to 0
        k = 0;
        for (int i = 0; i < 4; i++) begin
            t = cyc;
            speed_req = 1'b1;
            step_cyc(1);
            speed_req = 1'b0;
            chk("spd_level", 32'(speed), 32'((i + 1) % 4));
            chk("spd_led_hold", 32'(led), 32'((k == 0) ? 4'b0001 : sl[k-1]));
            for (int j = 1; j <= ns[i]; j++) begin
                push(sl[k], 2'd0, 2'((i + 1) % 4), t + 1 + j * per[i]);
                k++;
            end
            run_to(t + 1 + ns[i] * per[i]);
        end

        // Mode walk: L2R to 0100, then R2L, BOUNCE, BLINK
        t = cyc;
        push(4'b0001, 2'd0, 2'd0, t + 10);
        push(4'b0010, 2'd0, 2'd0, t + 20);
        push(4'b0100, 2'd0, 2'd0, t + 30);
        run_to(t + 35);
        mode_req = 1'b1;
        step_cyc(1);
        mode_req = 1'b0;
        state_chk("m_r2l", 4'b1000, 2'd1, 2'd0);
        mode_req = 1'b1;
        step_cyc(1);
        mode_req = 1'b0;
        state_chk("m_bounce", 4'b0001, 2'd2, 2'd0);
        t = cyc;
        for (int j = 0; j < 8; j++) push(bl[j], 2'd2, 2'd0, t + 10 * (j + 1));
        run_to(t + 80);
        mode_req = 1'b1;
        step_cyc(1);
        mode_req = 1'b0;
        state_chk("m_blink", 4'b1111, 2'd3, 2'd0);
        t = cyc;
        push(4'b0000, 2'd3, 2'd0, t + 10);
        push(4'b1111, 2'd3, 2'd0, t + 20);
        run_to(t + 20);

        // Pause at counter 4 for 50 cycles, then mode change while paused
        t = cyc;
        run_to(t + 4);
        pause = 1'b1;
        step_cyc(50);
        chk("pause_led", 32'(led), 32'(4'b1111));
        push(4'b0000, 2'd3, 2'd0, t + 60);
        pause = 1'b0;
        run_to(t + 60);
        pause = 1'b1;
        step_cyc(3);
        mode_req = 1'b1;
        step_cyc(1);
        mode_req = 1'b0;
        state_chk("pause_mode", 4'b0001, 2'd0, 2'd0);
        t = cyc;
        push(4'b0010, 2'd0, 2'd0, t + 15);
        step_cyc(5);
        pause = 1'b0;
        run_to(t + 15);

        // Both requests on the cycle the counter hits its limit
        t = cyc;
        run_to(t + 9);
        mode_req = 1'b1;
        speed_req = 1'b1;
        step_cyc(1);
        mode_req = 1'b0;
        speed_req = 1'b0;
        state_chk("sim", 4'b1000, 2'd1, 2'd1);
        chk("sim_tick", 32'(step_tick), 32'd0);
        t = cyc;
        push(4'b0100, 2'd1, 2'd1, t + 5);
        push(4'b0010, 2'd1, 2'd1, t + 10);
        run_to(t + 10);

        // BOUNCE at speed 2 heading down, then a one-cycle reset
        mode_req = 1'b1;
        speed_req = 1'b1;
        step_cyc(1);
        mode_req = 1'b0;
        speed_req = 1'b0;
        state_chk("b2", 4'b0001, 2'd2, 2'd2);
        t = cyc;
        push(4'b0010, 2'd2, 2'd2, t + 2);
        push(4'b0100, 2'd2, 2'd2, t + 4);
        push(4'b1000, 2'd2, 2'd2, t + 6);
        push(4'b0100, 2'd2, 2'd2, t + 8);
        run_to(t + 8);
        sys_rst = 1'b1;
        step_cyc(1);
        sys_rst = 1'b0;
        state_chk("mid_rst", 4'b0001, 2'd0, 2'd0);
        t = cyc;
        push(4'b0010, 2'd0, 2'd0, t + 10);
        push(4'b0100, 2'd0, 2'd0, t + 20);
        run_to(t + 20);
        step_cyc(3);
        chk("final_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/running_light_ctrl.md
# running_light_ctrl

Sequencer for the 4-LED running-light display: generates the step rate from the 50 MHz system clock and steps a 4-bit LED pattern through one of four display modes. Mode and speed are selected at run time by single-cycle request pulses from the (already debounced) key front-end. Sits between the key logic and the board LED pins and replaces the fixed 1 Hz shifter with a configurable scheduler.

## Interface
Parameters:
- `STEP_CNT_MAX`, default 24_999_999: base step period minus one, in `sys_clk` cycles (0.5 s at 50 MHz). The value must satisfy STEP_CNT_MAX+1 >= 8. Benches override it with 9.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk`  in  1  system clock, 50 MHz
- `sys_rst`  in  1  synchronous, active-high reset
- `mode_req`  in  1  one-cycle pulse: advance to the next mode
- `speed_req`  in  1  one-cycle pulse: advance to the next speed level
- `pause`  in  1  level: freeze stepping while high
- `led`  out  4  LED pattern; bit 0 is `led_0`
- `step_tick`  out  1  one-cycle pulse in the cycle after each pattern step
- `mode`  out  2  current mode
- `speed`  out  2  current speed level

## Operation
- **Modes:** 0 L2R, 1 R2L, 2 BOUNCE, 3 BLINK. `mode_req` cycles 0→1→2→3→0.
- **Step sequences:**
  - L2R: 0001→0010→0100→1000→0001.
  - R2L: 1000→0100→0010→0001→1000.
  - BOUNCE: 0001→0010→0100→1000→0100→0010→0001→0010…; an internal direction bit flips at 1000 and at 0001.
  - BLINK: 1111↔0000.
- **Mode change:** on the edge that samples `mode_req`:
  - `mode` increments.
  - `led` loads the new mode's seed pattern: L2R 0001, R2L 1000, BOUNCE 0001 with direction up, BLINK 1111.
  - The step counter clears.
  - No `step_tick` is produced for this change.
- **Speed:** level s gives a step period of (STEP_CNT_MAX+1)>>s cycles, so the limit is ((STEP_CNT_MAX+1)>>s)−1. `speed_req` cycles 0→1→2→3→0, clears the counter, and leaves `led` unchanged.
- **Simultaneous `mode_req` and `speed_req`:** both are applied in the same cycle.
- **Pause:** while `pause` is high:
  - The counter holds and no step or tick occurs.
  - `mode_req` and `speed_req` are still honoured, including the seed load and counter clear.
  - Stepping resumes from the held count when `pause` drops.
- **Counter rule:**
  - When counter == limit and pause is low: the counter wraps to 0, `led` advances one step, and `step_tick` is registered high.
  - Otherwise the counter increments.
  - A request pulse overrides a step in the same cycle; the request wins and there is no tick.

## Timing
- **Reset values:** `led`=0001, `mode`=0, `speed`=0, counter=0, direction=up, `step_tick`=0.
- All outputs are registered. `led`, `mode` and `speed` change on the clock edge that samples the triggering condition. `step_tick` is high during the cycle after the edge where `led` stepped, for exactly one cycle.
- **First step after reset release:** `led` advances on the (limit+1)th edge after the last edge with `sys_rst` high.
- **Reset mid-operation:** reset has priority over everything and returns all state to reset values on the next edge.
- **Counter width:** $clog2(STEP_CNT_MAX+1). The limit is computed combinationally from `speed`; no overflow is possible given the parameter constraint.

## Structure
- **Package `running_light_pkg`:**
  - mode encodings MODE_L2R/R2L/BOUNCE/BLINK (2-bit)
  - seed patterns per mode
  - speed level count (4)
- **Sub-module `step_timer`:**
  - inputs `sys_clk`, `sys_rst`, `clr`, `hold`, `speed`
  - output `step` (one-cycle)
  - holds the counter and limit logic
- **Top:** mode/speed registers, the pattern-step FSM (current pattern plus direction bit), and the `step_tick` register.

## Test plan
All scenarios use STEP_CNT_MAX=9.
1. **Reset then free-run at speed 0:** `led` reads 0001, 0010, 0100, 1000, 0001 at 10-cycle intervals; `step_tick` pulses once per step, one cycle late.
2. **Speed sweep:** `speed_req` pulsed three times, each followed by 3 steps; step intervals are 5, 2, 1 cycles. A 4th pulse returns `speed` to 0 and a 10-cycle interval.
3. **Mode walk:** `mode_req` in the L2R state at `led`=0100 loads R2L seed 1000 with no tick. The next `mode_req` loads BOUNCE; 8 steps give 0010,0100,1000,0100,0010,0001,0010,0100. The next loads BLINK, giving 1111,0000,1111.
4. **Pause:** `pause` high at counter=4 for 50 cycles gives no `led` change or tick. Releasing it steps after 5 more cycles. A `mode_req` during pause loads the seed immediately.
5. **Simultaneous events:** `mode_req`+`speed_req` in the same cycle as counter==limit gives `mode`+1, `speed`+1, the seed pattern, counter 0, and no `step_tick`.
6. **Reset mid-run:** `sys_rst` asserted for 1 cycle while in BOUNCE/speed 2/`led`=0100/direction down gives `led`=0001, `mode`=0, `speed`=0 next cycle. Stepping restarts upward after 10 cycles.
